hpm_counter_bank: RTL

Parametrised hardware-performance-monitor bank, successor to the fixed 6-bit-select perf counter block. It provides NumCounters programmable counters (mhpmcounter3..), each selecting one of NumEvents event lanes.
- Each lane carries a multi-bit per-cycle increment, so superscalar commit counts are exact rather than OR-reduced.
- Adds Sscofpmf-style privilege-mode filtering, per-counter overflow (OF) flags, LCOFI pulse and scountovf status.
- Sits beside csr_regfile; the CSR unit decodes privilege and forwards the raw 12-bit address.

---
 rtl/hpm_pkg.sv | 59 +++++
 rtl/hpm_counter.sv | 125 ++++++++++++
 rtl/hpm_counter_bank.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hpm_pkg.sv
// hpm_pkg: shared types, CSR address map and event-lane IDs for the
// hardware performance monitor counter bank.
package hpm_pkg;

  // Storage width of the event-select field.
  localparam int unsigned EVSEL_MAX_W = 8;

  typedef struct packed {
    logic                   of;
    logic                   minh;
    logic                   sinh;
    logic                   uinh;
    logic [EVSEL_MAX_W-1:0] sel;
  } mhpmevent_t;

  // Flag positions in a 64-bit mhpmevent view.
  localparam int unsigned EV_OF_BIT   = 63;
  localparam int unsigned EV_MINH_BIT = 62;
  localparam int unsigned EV_SINH_BIT = 61;
  localparam int unsigned EV_UINH_BIT = 60;

  // Flag positions inside mhpmeventh when XLEN=32.
  localparam int unsigned EVH_OF_BIT   = 31;
  localparam int unsigned EVH_MINH_BIT = 30;
  localparam int unsigned EVH_SINH_BIT = 29;
  localparam int unsigned EVH_UINH_BIT = 28;

  // CSR addresses of the first implemented counter (index 3).
  localparam logic [11:0] MHPM_COUNTER_3  = 12'hB03;
  localparam logic [11:0] MHPM_COUNTER_3H = 12'hB83;
  localparam logic [11:0] HPM_COUNTER_3   = 12'hC03;
  localparam logic [11:0] HPM_COUNTER_3H  = 12'hC83;
  localparam logic [11:0] MHPM_EVENT_3    = 12'h323;
  localparam logic [11:0] MHPM_EVENT_3H   = 12'h723;

  // Event lane IDs; lane 0 never counts.
  localparam int unsigned EV_NONE           = 0;
  localparam int unsigned EV_ICACHE_MISS    = 1;
  localparam int unsigned EV_DCACHE_MISS    = 2;
  localparam int unsigned EV_COMMIT_LOAD    = 3;
  localparam int unsigned EV_COMMIT_STORE   = 4;
  localparam int unsigned EV_COMMIT_BRANCH  = 5;
  localparam int unsigned EV_COMMIT_INSTR   = 6;
  localparam int unsigned EV_BRANCH_MISPRED = 7;
  localparam int unsigned EV_PIPE_STALL     = 8;

  // 64-bit architectural view of an event register.
  function automatic logic [63:0] ev_to_u64(input mhpmevent_t ev);
    logic [63:0] r;
    r                     = '0;
    r[EV_OF_BIT]          = ev.of;
    r[EV_MINH_BIT]        = ev.minh;
    r[EV_SINH_BIT]        = ev.sinh;
    r[EV_UINH_BIT]        = ev.uinh;
    r[EVSEL_MAX_W-1:0]    = ev.sel;
    return r;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// hpm_counter: one programmable counter with its mhpmevent register.
// Event mux, privilege/inhibit filter, adder, overflow detect and
// half-word write merge.
module hpm_counter
  import hpm_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 64,
  parameter int unsigned EvSelWidth   = 8,
  parameter int unsigned IncWidth     = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_debug,
  input  logic                          i_inhibit,
  input  logic                          i_freeze,
  input  logic [1:0]                    i_priv,
  input  logic [NumEvents*IncWidth-1:0] i_event_inc,
  input  logic                          i_cnt_we_lo,
  input  logic                          i_cnt_we_hi,
  input  logic                          i_ev_we_lo,
  input  logic                          i_ev_we_hi,
  input  logic [63:0]                   i_wdata,
  output logic [63:0]                   o_count,
  output logic [63:0]                   o_event,
  output logic                          o_of,
  output logic                          o_ovf_rise
);

  mhpmevent_t              r_ev;
  mhpmevent_t              w_ev_next;
  logic [CounterWidth-1:0] r_cnt;
  logic [CounterWidth-1:0] w_cnt_next;
  logic [CounterWidth:0]   w_sum;
  logic [63:0]             w_cnt64;
  logic [63:0]             w_wr64;
  logic [IncWidth-1:0]     w_inc;
  logic [EvSelWidth-1:0]   w_wsel;
  logic                    w_inh;
  logic                    w_cnt_we;
  logic                    w_en;
  logic                    w_carry;
  logic                    w_unused_lane0;

  assign w_unused_lane0 = ^i_event_inc[IncWidth-1:0];
  assign w_cnt64        = 64'(r_cnt);
  assign w_wsel         = i_wdata[EvSelWidth-1:0];
  assign w_cnt_we       = i_cnt_we_lo | i_cnt_we_hi;

  // Select the increment of the chosen lane; lane 0 is never routed
  always_comb begin
    w_inc = '0;
    for (int unsigned e = 1; e < NumEvents; e++)
      if (32'(r_ev.sel) == e) w_inc = i_event_inc[e*IncWidth +: IncWidth];
  end

  // Privilege-mode filter from the event register's inhibit bits
  always_comb begin
    w_inh = 1'b0;
    case (i_priv)
      2'd3:    w_inh = r_ev.minh;
      2'd1:    w_inh = r_ev.sinh;
      2'd0:    w_inh = r_ev.uinh;
      default: w_inh = 1'b0;
    endcase
  end

  assign w_en    = !i_debug && !i_inhibit && !i_freeze && !w_inh &&
                   (32'(r_ev.sel) < NumEvents) && !w_cnt_we;
  assign w_sum   = {1'b0, r_cnt} + (CounterWidth+1)'(w_inc);
  assign w_carry = w_en & w_sum[CounterWidth];

  // Counter next value: software write replaces the addressed half and wins
  always_comb begin
    w_wr64 = w_cnt64;
    if (XLEN == 64) begin
      if (i_cnt_we_lo) w_wr64 = i_wdata;
    end else begin
      if (i_cnt_we_lo) w_wr64[31:0]  = i_wdata[31:0];
      if (i_cnt_we_hi) w_wr64[63:32] = i_wdata[31:0];
    end
    w_cnt_next = r_cnt;
    if (w_cnt_we)  w_cnt_next = CounterWidth'(w_wr64);
    else if (w_en) w_cnt_next = w_sum[CounterWidth-1:0];
  end

  // Event register next value: WARL select, flags, overflow sets OF
  always_comb begin
    w_ev_next = r_ev;
    if (XLEN == 64) begin
      if (i_ev_we_lo) begin
        w_ev_next.of   = i_wdata[EV_OF_BIT];
        w_ev_next.minh = i_wdata[EV_MINH_BIT];
        w_ev_next.sinh = i_wdata[EV_SINH_BIT];
        w_ev_next.uinh = i_wdata[EV_UINH_BIT];
      end
    end else if (i_ev_we_hi) begin
      w_ev_next.of   = i_wdata[EVH_OF_BIT];
      w_ev_next.minh = i_wdata[EVH_MINH_BIT];
      w_ev_next.sinh = i_wdata[EVH_SINH_BIT];
      w_ev_next.uinh = i_wdata[EVH_UINH_BIT];
    end
    if (i_ev_we_lo)
      w_ev_next.sel = (32'(w_wsel) < NumEvents) ? EVSEL_MAX_W'(w_wsel) : '0;
    if (w_carry) w_ev_next.of = 1'b1;
  end

  // Counter and event state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ev  <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ev  <= w_ev_next;
    end
  end

  assign o_count    = w_cnt64;
  assign o_event    = ev_to_u64(r_ev);
  assign o_of       = r_ev.of;
  assign o_ovf_rise = w_carry & ~r_ev.of;

endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: NumCounters programmable HPM counters (index 3..),
// CSR decode/read mux, scountovf and LCOFI pulse.
// Optional macro HPM_FREEZE_ON_OVF_EN: any set OF bit stops all counting.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int unsigned NumCounters  = 29,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 64,
  parameter int unsigned EvSelWidth   = 8,
  parameter int unsigned IncWidth     = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          debug_mode_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic [31:0]                   mcountinhibit_i,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic                          csr_we_i,
  input  logic [XLEN-1:0]               csr_wdata_i,
  output logic [XLEN-1:0]               csr_rdata_o,
  output logic                          csr_hit_o,
  output logic                          csr_illegal_o,
  output logic                          lcofi_o,
  output logic [31:0]                   scountovf_o
);

  logic [4:0]             w_idx;
  logic [4:0]             w_slot;
  logic [6:0]             w_blk;
  logic                   w_in_range, w_slot_ok;
  logic                   w_mcnt, w_mcnth, w_cnt, w_cnth, w_ev, w_evh;
  logic                   w_any_h, w_hit, w_illegal, w_wr, w_freeze;
  logic [63:0]            w_wdata64;
  logic [63:0]            w_rd_cnt, w_rd_ev, w_rdata64;
  logic [63:0]            w_count [NumCounters];
  logic [63:0]            w_event [NumCounters];
  logic [NumCounters-1:0] w_of, w_rise;
  logic                   r_lcofi;
  logic                   w_unused_inh;

  assign w_unused_inh = ^mcountinhibit_i;
  assign w_wdata64    = 64'(csr_wdata_i);

  assign w_idx      = csr_addr_i[4:0];
  assign w_blk      = csr_addr_i[11:5];
  assign w_in_range = (w_idx >= 5'd3);
  assign w_slot     = w_idx - 5'd3;
  assign w_slot_ok  = w_in_range && (32'(w_slot) < NumCounters);

  assign w_mcnt  = w_in_range && (w_blk == MHPM_COUNTER_3[11:5]);
  assign w_mcnth = w_in_range && (w_blk == MHPM_COUNTER_3H[11:5]);
  assign w_cnt   = w_in_range && (w_blk == HPM_COUNTER_3[11:5]);
  assign w_cnth  = w_in_range && (w_blk == HPM_COUNTER_3H[11:5]);
  assign w_ev    = w_in_range && (w_blk == MHPM_EVENT_3[11:5]);
  assign w_evh   = w_in_range && (w_blk == MHPM_EVENT_3H[11:5]);

  assign w_any_h   = w_mcnth | w_cnth | w_evh;
  assign w_hit     = w_mcnt | w_mcnth | w_cnt | w_cnth | w_ev | w_evh;
  assign w_illegal = ((XLEN == 64) && w_any_h) || (csr_we_i && (w_cnt || w_cnth));
  assign w_wr      = csr_we_i && !w_illegal && w_slot_ok;

`ifdef HPM_FREEZE_ON_OVF_EN
  assign w_freeze = |w_of;
`else
  assign w_freeze = 1'b0;
`endif

  for (genvar k = 0; k < NumCounters; k++) begin : g_ctr
    logic w_sel_k;
    assign w_sel_k = w_wr && (32'(w_slot) == 32'(k));

    hpm_counter #(
      .CounterWidth(CounterWidth),
      .NumEvents   (NumEvents),
      .EvSelWidth  (EvSelWidth),
      .IncWidth    (IncWidth),
      .XLEN        (XLEN)
    ) u_ctr (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_debug    (debug_mode_i),
      .i_inhibit  (mcountinhibit_i[k+3]),
      .i_freeze   (w_freeze),
      .i_priv     (priv_lvl_i),
      .i_event_inc(event_inc_i),
      .i_cnt_we_lo(w_sel_k && w_mcnt),
      .i_cnt_we_hi(w_sel_k && w_mcnth),
      .i_ev_we_lo (w_sel_k && w_ev),
      .i_ev_we_hi (w_sel_k && w_evh),
      .i_wdata    (w_wdata64),
      .o_count    (w_count[k]),
      .o_event    (w_event[k]),
      .o_of       (w_of[k]),
      .o_ovf_rise (w_rise[k])
    );
  end

  // Fetch the addressed counter and event register
  always_comb begin
    w_rd_cnt = '0;
    w_rd_ev  = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (w_slot_ok && (32'(w_slot) == k)) begin
        w_rd_cnt = w_count[k];
        w_rd_ev  = w_event[k];
      end
    end
  end

  // Format read data by address class and XLEN
  always_comb begin
    w_rdata64 = '0;
    if (!w_illegal) begin
      if (w_mcnt || w_cnt)
        w_rdata64 = (XLEN == 64) ? w_rd_cnt : {32'b0, w_rd_cnt[31:0]};
      else if (w_mcnth || w_cnth)
        w_rdata64 = {32'b0, w_rd_cnt[63:32]};
      else if (w_ev)
        w_rdata64 = (XLEN == 64) ? w_rd_ev : {32'b0, w_rd_ev[31:0]};
      else if (w_evh)
        w_rdata64 = {32'b0, w_rd_ev[63:32]};
    end
  end

  // Map per-counter OF bits onto their architectural index
  always_comb begin
    scountovf_o = '0;
    for (int unsigned k = 0; k < NumCounters; k++) scountovf_o[k+3] = w_of[k];
  end

  // One LCOFI pulse per cycle in which any OF bit rises
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lcofi <= 1'b0;
    else       r_lcofi <= |w_rise;
  end

  assign csr_rdata_o   = XLEN'(w_rdata64);
  assign csr_hit_o     = w_hit;
  assign csr_illegal_o = w_illegal;
  assign lcofi_o       = r_lcofi;

endmodule
